// File: rtl/transpose_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : transpose_pkg
//  Purpose  : Shared types, constants and lane helper for the transpose buffer
//  Revision : 1.0  initial release
// ============================================================================
package transpose_pkg;

  // Per-matrix output ordering, captured with the first row of each matrix
  typedef enum logic {
    MODE_TRANSPOSE = 1'b0,
    MODE_PASS      = 1'b1
  } mode_e;

  // Default configuration of the buffer
  localparam int CFG_N      = 8;
  localparam int CFG_DATA_W = 8;
  localparam int CFG_VEC_W  = CFG_N * CFG_DATA_W;
  localparam int CFG_IDX_W  = $clog2(CFG_N);

  // Element e of a packed vector; element 0 sits in the MSB lane
  function automatic logic [CFG_DATA_W-1:0] lane(input logic [CFG_VEC_W-1:0] vec,
                                                 input int unsigned e);
    return CFG_DATA_W'(vec >> ((CFG_N - 1 - int'(e)) * CFG_DATA_W));
  endfunction

endpackage
`default_nettype wire

// File: rtl/transpose_bank.sv
`default_nettype none
// ============================================================================
//  Module   : transpose_bank
//  Purpose  : One N x N element storage bank with a row write port and a
//             combinational column/row read mux
//  Revision : 1.0  initial release
// ============================================================================
module transpose_bank
  import transpose_pkg::*;
#(
  parameter int N      = CFG_N,
  parameter int DATA_W = CFG_DATA_W
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(N)-1:0]       wr_row,
  input  logic [N*DATA_W-1:0]        wr_data,
  input  mode_e                      mode,
  input  logic [$clog2(N)-1:0]       rd_idx,
  output logic [N*DATA_W-1:0]        rd_vec
);

  localparam int VEC_W = N * DATA_W;
  localparam int IDX_W = $clog2(N);

  // Storage is never reset; a bank is only read after all N rows are written
  logic [VEC_W-1:0] rows [N];
  logic [VEC_W-1:0] col_vec;

  // Row write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      rows[wr_row] <= wr_data;
    end
  end

  // Column gather: output lane k takes element rd_idx of stored row k
  always_comb begin
    col_vec = '0;
    for (int k = 0; k < N; k++) begin
      for (int e = 0; e < N; e++) begin
        if (rd_idx == IDX_W'(e)) begin
          col_vec[(N-1-k)*DATA_W +: DATA_W] = rows[k][(N-1-e)*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign rd_vec = (mode == MODE_PASS) ? rows[rd_idx] : col_vec;

endmodule
`default_nettype wire

// File: rtl/transpose_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : transpose_buffer
//  Purpose  : Ping-pong N x N buffer that takes packed rows and emits packed
//             columns (transpose) or the rows unchanged (pass-through)
//  Revision : 1.0  initial release
// ============================================================================
module transpose_buffer
  import transpose_pkg::*;
#(
  parameter int N      = CFG_N,
  parameter int DATA_W = CFG_DATA_W
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [N*DATA_W-1:0]   in_row_i,
  input  logic                  mode_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [N*DATA_W-1:0]   out_vec_o,
  output logic                  out_last_o,
  output logic [1:0]            bank_full_o
);

  localparam int VEC_W = N * DATA_W;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] wr_row;
  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       full;
  mode_e            bank_mode [2];
  logic [VEC_W-1:0] bank_vec  [2];
  logic             accept;
  logic             fire;

  // Handshakes come straight from registers; after reset nothing is full so
  // ready is the one output that comes up high
  assign in_ready_o  = !full[wr_bank];
  assign out_valid_o = full[rd_bank];
  assign accept      = in_valid_i && in_ready_o;
  assign fire        = out_valid_o && out_ready_i;

  assign out_vec_o   = out_valid_o ? bank_vec[rd_bank] : '0;
  assign out_last_o  = out_valid_o && (rd_idx == LAST_IDX);
  assign bank_full_o = full;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    transpose_bank #(
      .N      (N),
      .DATA_W (DATA_W)
    ) u_bank (
      .clk     (clk_i),
      .wr_en   (accept && (wr_bank == 1'(b))),
      .wr_row  (wr_row),
      .wr_data (in_row_i),
      .mode    (bank_mode[b]),
      .rd_idx  (rd_idx),
      .rd_vec  (bank_vec[b])
    );
  end

  // Write and read pointers; a bank is written only while empty and read only
  // while full, so the two sides never touch the same full bit in one cycle
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_row       <= '0;
      rd_idx       <= '0;
      full         <= 2'b00;
      bank_mode[0] <= MODE_TRANSPOSE;
      bank_mode[1] <= MODE_TRANSPOSE;
    end else begin
      if (accept) begin
        if (wr_row == '0) begin
          bank_mode[wr_bank] <= mode_e'(mode_i);
        end
        if (wr_row == LAST_IDX) begin
          wr_row        <= '0;
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end else begin
          wr_row <= wr_row + IDX_W'(1);
        end
      end
      if (fire) begin
        if (rd_idx == LAST_IDX) begin
          rd_idx        <= '0;
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end else begin
          rd_idx <= rd_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_transpose_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_transpose_buffer
//  Purpose  : Directed self-checking bench for transpose_buffer (N=8, 8-bit)
//  Revision : 1.0  initial release
// ============================================================================
module tb_transpose_buffer;
  import transpose_pkg::*;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [63:0] in_row_i = '0;
  logic        mode_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [63:0] out_vec_o;
  logic        out_last_o;
  logic [1:0]  bank_full_o;

  int checks = 0;
  int failures = 0;

  transpose_buffer #(.N(8), .DATA_W(8)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_row_i    (in_row_i),
    .mode_i      (mode_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_vec_o   (out_vec_o),
    .out_last_o  (out_last_o),
    .bank_full_o (bank_full_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Element e of row r of matrix m; the matrix id scrambles both nibbles
  function automatic logic [7:0] elem(input int m, input int r, input int e);
    logic [3:0] rn;
    logic [3:0] en;
    rn = 4'(r);
    en = 4'(e);
    return {rn, en} ^ 8'(m * 17);
  endfunction

  function automatic logic [63:0] row_of(input int m, input int r);
    logic [63:0] v = '0;
    for (int e = 0; e < 8; e++) v = (v << 8) | 64'(elem(m, r, e));
    return v;
  endfunction

  // Beat k: transpose -> lane j is row j element k; pass -> row k itself
  function automatic logic [63:0] exp_beat(input int m, input logic md, input int k);
    logic [63:0] v = '0;
    for (int j = 0; j < 8; j++) v = (v << 8) | 64'(md ? elem(m, k, j) : elem(m, j, k));
    return v;
  endfunction

  task automatic reset_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid_o), 64'd0);
    chk({tag, "_vec"},   out_vec_o,        64'd0);
    chk({tag, "_last"},  64'(out_last_o),  64'd0);
    chk({tag, "_full"},  64'(bank_full_o), 64'd0);
    chk({tag, "_ready"}, 64'(in_ready_o),  64'd1);
  endtask

  task automatic push(input int m, input logic md, input int r0, input int r1, input bit idle);
    for (int r = r0; r < r1; r++) begin
      @(negedge clk);
      chk("push_ready", 64'(in_ready_o), 64'd1);
      if (idle) chk("push_idle", 64'(out_valid_o), 64'd0);
      in_valid_i = 1'b1;
      in_row_i   = row_of(m, r);
      mode_i     = md;
    end
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic drain(input int m, input logic md, input int hand_k,
                       input logic [63:0] hand, input bit blocked);
    out_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      chk("drain_valid", 64'(out_valid_o), 64'd1);
      chk("drain_vec",   out_vec_o, exp_beat(m, md, k));
      chk("drain_last",  64'(out_last_o), 64'(k == 7));
      if (k == hand_k) chk("drain_hand", out_vec_o, hand);
      if (blocked) chk("drain_blocked", 64'(in_ready_o), 64'd0);
    end
    @(negedge clk);
    out_ready_i = 1'b0;
  endtask

  task automatic stream(input int base, input int n_mat, input logic [3:0] modes,
                        input bit rand_ready, input bit need_ready);
    int in_cnt = 0;
    int out_cnt = 0;
    int cyc = 0;
    int total = n_mat * 8;
    bit prev_stall = 1'b0;
    logic [63:0] prev_vec = '0;
    while (out_cnt < total && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) chk("stall_valid", 64'(out_valid_o), 64'd1);
      if (out_valid_o) begin
        chk("stream_vec",  out_vec_o, exp_beat(base + out_cnt / 8, modes[out_cnt / 8], out_cnt % 8));
        chk("stream_last", 64'(out_last_o), 64'((out_cnt % 8) == 7));
        if (prev_stall) chk("stall_hold", out_vec_o, prev_vec);
      end else begin
        chk("idle_vec",  out_vec_o, 64'd0);
        chk("idle_last", 64'(out_last_o), 64'd0);
      end
      out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall  = out_valid_o && !out_ready_i;
      prev_vec    = out_vec_o;
      if (out_valid_o && out_ready_i) out_cnt++;
      if (in_cnt < total) begin
        in_valid_i = 1'b1;
        in_row_i   = row_of(base + in_cnt / 8, in_cnt % 8);
        mode_i     = modes[in_cnt / 8];
        if (need_ready) chk("stream_ready", 64'(in_ready_o), 64'd1);
        if (in_ready_o) in_cnt++;
      end else begin
        in_valid_i = 1'b0;
      end
    end
    chk("stream_count", 64'(out_cnt), 64'(total));
    @(negedge clk);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    chk("stream_empty", 64'(out_valid_o), 64'd0);
    chk("stream_full",  64'(bank_full_o), 64'd0);
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    reset_zero("rst");

    // Transpose of the reference matrix, latency and hand-computed beats
    push(0, 1'b0, 0, 8, 1'b1);
    chk("t_first_valid", 64'(out_valid_o), 64'd1);
    chk("t_beat0", out_vec_o, 64'h0010203040506070);
    chk("t_beat0_lane3", 64'(lane(out_vec_o, 3)), 64'h30);
    drain(0, 1'b0, 7, 64'h0717273747576777, 1'b0);
    chk("t_done", 64'(out_valid_o), 64'd0);

    // Pass-through of the same matrix (lands in bank 1)
    push(0, 1'b1, 0, 8, 1'b1);
    drain(0, 1'b1, 3, 64'h3031323334353637, 1'b0);
    chk("p_done", 64'(out_valid_o), 64'd0);

    // Continuous stream of four matrices, modes 0,1,0,1
    stream(4, 4, 4'b1010, 1'b0, 1'b1);

    // Random output backpressure, modes 1,0,1
    stream(8, 3, 4'b0101, 1'b1, 1'b0);

    // Reset after five rows discards the partial matrix
    push(15, 1'b0, 0, 5, 1'b1);
    rstn_i = 1'b0;
    @(negedge clk);
    rstn_i = 1'b1;
    reset_zero("rst5");
    @(negedge clk);
    chk("rst5_no_beat", 64'(out_valid_o), 64'd0);

    // Both banks full with output stalled
    push(11, 1'b0, 0, 8, 1'b1);
    chk("bp_full01", 64'(bank_full_o), 64'd1);
    push(12, 1'b1, 0, 8, 1'b0);
    chk("bp_full11", 64'(bank_full_o), 64'd3);
    in_valid_i = 1'b1;
    in_row_i   = row_of(13, 0);
    mode_i     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_held", 64'(in_ready_o), 64'd0);
      @(negedge clk);
    end
    drain(11, 1'b0, -1, 64'd0, 1'b1);
    chk("bp_ready_after", 64'(in_ready_o), 64'd1);
    chk("bp_full10", 64'(bank_full_o), 64'd2);
    push(13, 1'b0, 1, 8, 1'b0);
    drain(12, 1'b1, -1, 64'd0, 1'b0);
    drain(13, 1'b0, -1, 64'd0, 1'b0);
    chk("bp_done", 64'(out_valid_o), 64'd0);

    // Reset in the middle of a drain
    push(14, 1'b1, 0, 8, 1'b1);
    out_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    out_ready_i = 1'b0;
    rstn_i = 1'b0;
    @(negedge clk);
    rstn_i = 1'b1;
    reset_zero("rstd");
    @(negedge clk);
    chk("rstd_no_beat", 64'(out_valid_o), 64'd0);
    stream(20, 1, 4'b0001, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
